// File: rtl/sd_spi_responder_if.sv
// Pin bundle between an SPI-mode SD host and the card emulator, including the
// emulator's block-memory read port and its command/status observation outputs.
interface sd_spi_responder_if;
  logic        spi_cs;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        mem_rd;
  logic [31:0] mem_lba;
  logic [8:0]  mem_offset;
  logic [7:0]  mem_data;
  logic        idle_state;
  logic        cmd_strobe;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  modport master (
    output spi_cs, spi_sclk, spi_mosi, mem_data,
    input  spi_miso, mem_rd, mem_lba, mem_offset,
    input  idle_state, cmd_strobe, cmd_index, cmd_arg
  );

  modport slave (
    input  spi_cs, spi_sclk, spi_mosi, mem_data,
    output spi_miso, mem_rd, mem_lba, mem_offset,
    output idle_state, cmd_strobe, cmd_index, cmd_arg
  );
endinterface

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card emulator: decodes 6-byte command frames, answers R1/R3/R7,
// models the idle->ready init sequence and serves CMD17 reads from a byte memory.
module sd_spi_responder #(
  parameter int unsigned NCR          = 1,
  parameter int unsigned INIT_RETRIES = 3,
  parameter int unsigned NAC          = 2,
  parameter int unsigned SDHC         = 1
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  sd_spi_responder_if.slave   io_bus
);

  localparam int unsigned CW = 10;
  localparam logic [31:0]   OCR        = (SDHC != 0) ? 32'hC0FF_8000 : 32'h80FF_8000;
  localparam logic [CW-1:0] L_NCR      = CW'(NCR);
  localparam logic [CW-1:0] L_NAC      = CW'(NAC);
  localparam logic [CW-1:0] L_D0       = CW'(NAC + 1);
  localparam logic [CW-1:0] L_DLAST    = CW'(NAC + 512);
  localparam logic [CW-1:0] L_RDLAST   = CW'(NAC + 511);
  localparam logic [CW-1:0] L_END      = CW'(NAC + 515);
  localparam logic [3:0]    L_RETRIES  = 4'(INIT_RETRIES);

  typedef enum logic [2:0] {S_WAIT_CMD, S_ARG, S_NCR, S_RESP, S_DATA} state_t;

  logic [1:0]    r_cs_s, r_sclk_s, r_mosi_s;
  logic          r_sclk_d;
  state_t        r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_rx, r_tx;
  logic          r_miso;
  logic [CW-1:0] r_cnt;
  logic [5:0]    r_idx;
  logic [31:0]   r_arg;
  logic [39:0]   r_resp;
  logic [2:0]    r_resp_len;
  logic          r_go_data;
  logic          r_idle, r_app;
  logic [3:0]    r_retry;
  logic          r_cmd_strobe;
  logic [5:0]    r_cmd_index;
  logic [31:0]   r_cmd_arg;
  logic          r_mem_rd, r_mem_rd_d;
  logic [31:0]   r_mem_lba;
  logic [8:0]    r_mem_offset;
  logic [7:0]    r_mem_byte;

  logic          w_cs, w_rise, w_fall;
  logic [7:0]    w_byte;
  logic [39:0]   w_resp;
  logic [2:0]    w_resp_len;
  logic          w_go_data, w_idle_nx;
  logic [3:0]    w_retry_nx;
  logic [7:0]    w_r1;

  assign w_cs   = r_cs_s[1];
  assign w_rise = r_sclk_s[1] & ~r_sclk_d;
  assign w_fall = ~r_sclk_s[1] & r_sclk_d;
  assign w_byte = {r_rx[6:0], r_mosi_s[1]};
  assign w_r1   = {7'b0, r_idle};

  // Response bytes (MSB-first, 0xFF padded) and card-state updates for the frame just received
  always_comb begin
    w_resp     = {8'h00, 32'hFFFF_FFFF};
    w_resp_len = 3'd1;
    w_go_data  = 1'b0;
    w_idle_nx  = r_idle;
    w_retry_nx = r_retry;
    case (r_idx)
      6'd0: begin
        w_resp     = {8'h01, 32'hFFFF_FFFF};
        w_idle_nx  = 1'b1;
        w_retry_nx = 4'd0;
      end
      6'd8: begin
        w_resp     = {w_r1, 8'h00, 8'h00, 4'h0, r_arg[11:8], r_arg[7:0]};
        w_resp_len = 3'd5;
      end
      6'd55: w_resp = {w_r1, 32'hFFFF_FFFF};
      6'd41: begin
        if (!r_app) begin
          w_resp = {w_r1 | 8'h04, 32'hFFFF_FFFF};
        end else if (r_retry < L_RETRIES) begin
          w_resp     = {8'h01, 32'hFFFF_FFFF};
          w_retry_nx = r_retry + 4'd1;
        end else begin
          w_resp    = {8'h00, 32'hFFFF_FFFF};
          w_idle_nx = 1'b0;
        end
      end
      6'd58: begin
        w_resp     = {w_r1, OCR};
        w_resp_len = 3'd5;
      end
      6'd17: begin
        if (r_idle) begin
          w_resp = {8'h05, 32'hFFFF_FFFF};
        end else begin
          w_resp    = {8'h00, 32'hFFFF_FFFF};
          w_go_data = 1'b1;
        end
      end
      default: w_resp = {w_r1 | 8'h04, 32'hFFFF_FFFF};
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cs_s       <= 2'b11;
      r_sclk_s     <= 2'b00;
      r_mosi_s     <= 2'b11;
      r_sclk_d     <= 1'b0;
      r_state      <= S_WAIT_CMD;
      r_bitcnt     <= 3'd0;
      r_rx         <= 8'h00;
      r_tx         <= 8'hFF;
      r_miso       <= 1'b1;
      r_cnt        <= '0;
      r_idx        <= 6'd0;
      r_arg        <= 32'd0;
      r_resp       <= '1;
      r_resp_len   <= 3'd1;
      r_go_data    <= 1'b0;
      r_idle       <= 1'b1;
      r_app        <= 1'b0;
      r_retry      <= 4'd0;
      r_cmd_strobe <= 1'b0;
      r_cmd_index  <= 6'd0;
      r_cmd_arg    <= 32'd0;
      r_mem_rd     <= 1'b0;
      r_mem_rd_d   <= 1'b0;
      r_mem_lba    <= 32'd0;
      r_mem_offset <= 9'd0;
      r_mem_byte   <= 8'hFF;
    end else begin
      r_cs_s       <= {r_cs_s[0], io_bus.spi_cs};
      r_sclk_s     <= {r_sclk_s[0], io_bus.spi_sclk};
      r_mosi_s     <= {r_mosi_s[0], io_bus.spi_mosi};
      r_sclk_d     <= r_sclk_s[1];
      r_cmd_strobe <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_rd_d   <= r_mem_rd;
      if (r_mem_rd_d) r_mem_byte <= io_bus.mem_data;

      if (w_cs) begin
        // Deselect drops any transfer but keeps the card's init state
        r_state  <= S_WAIT_CMD;
        r_bitcnt <= 3'd0;
        r_rx     <= 8'h00;
        r_tx     <= 8'hFF;
        r_miso   <= 1'b1;
        r_cnt    <= '0;
      end else if (w_fall) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b1};
      end else if (w_rise) begin
        r_rx     <= w_byte;
        r_bitcnt <= r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) begin
          r_tx <= 8'hFF;
          case (r_state)
            S_WAIT_CMD: begin
              if (w_byte[7:6] == 2'b01) begin
                r_idx   <= w_byte[5:0];
                r_cnt   <= '0;
                r_state <= S_ARG;
              end
            end
            S_ARG: begin
              if (r_cnt == CW'(4)) begin
                r_cmd_index  <= r_idx;
                r_cmd_arg    <= r_arg;
                r_cmd_strobe <= 1'b1;
                r_resp       <= w_resp;
                r_resp_len   <= w_resp_len;
                r_go_data    <= w_go_data;
                r_idle       <= w_idle_nx;
                r_retry      <= w_retry_nx;
                r_app        <= (r_idx == 6'd55);
                if (w_go_data) r_mem_lba <= r_arg;
                r_cnt   <= CW'(1);
                r_state <= S_NCR;
              end else begin
                r_arg <= {r_arg[23:0], w_byte};
                r_cnt <= r_cnt + CW'(1);
              end
            end
            S_NCR: begin
              if (r_cnt == L_NCR) begin
                r_tx    <= r_resp[39:32];
                r_resp  <= {r_resp[31:0], 8'hFF};
                r_cnt   <= CW'(1);
                r_state <= S_RESP;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            S_RESP: begin
              if (r_cnt == CW'(r_resp_len)) begin
                r_cnt   <= CW'(1);
                r_state <= r_go_data ? S_DATA : S_WAIT_CMD;
              end else begin
                r_tx   <= r_resp[39:32];
                r_resp <= {r_resp[31:0], 8'hFF};
                r_cnt  <= r_cnt + CW'(1);
              end
            end
            S_DATA: begin
              // r_cnt indexes the data-phase byte being loaded: NAC fillers, token, 512 data, 2 CRC
              if (r_cnt == L_END) begin
                r_state <= S_WAIT_CMD;
              end else begin
                if (r_cnt == L_NAC) r_tx <= 8'hFE;
                else if (r_cnt >= L_D0 && r_cnt <= L_DLAST) r_tx <= r_mem_byte;
                r_cnt <= r_cnt + CW'(1);
              end
              if (r_cnt >= L_NAC && r_cnt <= L_RDLAST) begin
                r_mem_rd     <= 1'b1;
                r_mem_offset <= 9'(r_cnt - L_NAC);
              end
            end
            default: r_state <= S_WAIT_CMD;
          endcase
        end
      end
    end
  end

  assign io_bus.spi_miso   = r_miso;
  assign io_bus.mem_rd     = r_mem_rd;
  assign io_bus.mem_lba    = r_mem_lba;
  assign io_bus.mem_offset = r_mem_offset;
  assign io_bus.idle_state = r_idle;
  assign io_bus.cmd_strobe = r_cmd_strobe;
  assign io_bus.cmd_index  = r_cmd_index;
  assign io_bus.cmd_arg    = r_cmd_arg;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Scoreboard bench for sd_spi_responder: an SD-card behaviour model predicts MISO bytes,
// command strobes and memory fetches; one monitor pops and compares what the DUT presents.
module tb_sd_spi_responder;
  localparam int NCR          = 1;
  localparam int INIT_RETRIES = 3;
  localparam int NAC          = 2;
  localparam int SDHC         = 1;
  localparam int HALF         = 4;
  localparam logic [31:0] OCR = 32'hC0FF_8000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_spi_responder_if bus();

  sd_spi_responder #(.NCR(NCR), .INIT_RETRIES(INIT_RETRIES), .NAC(NAC), .SDHC(SDHC)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .io_bus    (bus)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] lba, input int off);
    return 8'(off) ^ lba[7:0];
  endfunction

  // Block memory: data valid one clock after the read strobe
  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem_byte(bus.mem_lba, int'({23'd0, bus.mem_offset}));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0]  q_miso[$];
  logic [37:0] q_cmd[$];
  int          rd_count = 0;
  int          rd_base  = 0;
  logic [31:0] exp_lba  = 32'd0;
  int          strobe_count = 0;

  // Card model
  logic        m_idle = 1'b1;
  logic        m_app  = 1'b0;
  int          m_retry = 0;
  logic [7:0]  resp_q[$];
  logic        exp_data;

  task automatic model(input logic [5:0] idx, input logic [31:0] arg);
    logic [7:0] r1;
    r1 = {7'b0, m_idle};
    resp_q.delete();
    exp_data = 1'b0;
    case (idx)
      6'd0: begin resp_q.push_back(8'h01); m_idle = 1'b1; m_retry = 0; end
      6'd8: begin
        resp_q.push_back(r1); resp_q.push_back(8'h00); resp_q.push_back(8'h00);
        resp_q.push_back({4'h0, arg[11:8]}); resp_q.push_back(arg[7:0]);
      end
      6'd55: resp_q.push_back(r1);
      6'd41: begin
        if (!m_app) resp_q.push_back(r1 | 8'h04);
        else if (m_retry < INIT_RETRIES) begin resp_q.push_back(8'h01); m_retry++; end
        else begin resp_q.push_back(8'h00); m_idle = 1'b0; end
      end
      6'd58: begin
        resp_q.push_back(r1);
        for (int k = 3; k >= 0; k--) resp_q.push_back(8'(OCR >> (8 * k)));
      end
      6'd17: begin
        if (m_idle) resp_q.push_back(8'h05);
        else begin resp_q.push_back(8'h00); exp_data = 1'b1; end
      end
      default: resp_q.push_back(r1 | 8'h04);
    endcase
    m_app = (idx == 6'd55);
  endtask

  task automatic xfer(input logic [7:0] tx_b, input logic [7:0] exp_b);
    q_miso.push_back(exp_b);
    for (int i = 7; i >= 0; i--) begin
      bus.spi_mosi = tx_b[i];
      repeat (HALF) @(negedge clk);
      bus.spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sclk = 1'b0;
    end
  endtask

  // One command frame plus its response; data_limit<0 reads the whole data phase
  task automatic cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc, input int data_limit);
    int n;
    logic [7:0] e;
    model(idx, arg);
    q_cmd.push_back({idx, arg});
    xfer({2'b01, idx}, 8'hFF);
    for (int k = 3; k >= 0; k--) xfer(8'(arg >> (8 * k)), 8'hFF);
    xfer(crc, 8'hFF);
    for (int k = 0; k < NCR; k++) xfer(8'($urandom), 8'hFF);
    foreach (resp_q[k]) xfer(8'($urandom), resp_q[k]);
    if (exp_data) begin
      rd_base = rd_count;
      exp_lba = arg;
      n = (data_limit < 0) ? NAC + 515 : data_limit;
      for (int j = 0; j < n; j++) begin
        if (j < NAC)             e = 8'hFF;
        else if (j == NAC)       e = 8'hFE;
        else if (j <= NAC + 512) e = mem_byte(arg, j - NAC - 1);
        else                     e = 8'hFF;
        xfer(8'($urandom), e);
      end
    end
  endtask

  // Single monitor: MISO bytes, command strobes and memory fetches
  initial begin : monitor
    logic       prev_sclk;
    logic [7:0] sh;
    logic [7:0] e;
    logic [37:0] c;
    int         nb;
    prev_sclk = 1'b0;
    sh = 8'h00;
    nb = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.cmd_strobe) begin
        strobe_count++;
        if (q_cmd.size() == 0) chk("cmd_strobe_unexpected", 32'(strobe_count), 32'(0));
        else begin
          c = q_cmd.pop_front();
          chk("cmd_index", 32'(bus.cmd_index), 32'(c[37:32]));
          chk("cmd_arg", bus.cmd_arg, c[31:0]);
        end
      end
      if (bus.mem_rd) begin
        chk("mem_offset", 32'(bus.mem_offset), 32'(rd_count - rd_base));
        chk("mem_lba", bus.mem_lba, exp_lba);
        rd_count++;
      end
      if (!bus.spi_cs && bus.spi_sclk && !prev_sclk) begin
        sh = {sh[6:0], bus.spi_miso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (q_miso.size() == 0) chk("miso_byte_unexpected", 32'(sh), 32'hFFFF_FFFF);
          else begin
            e = q_miso.pop_front();
            chk("miso_byte", 32'(sh), 32'(e));
          end
        end
      end
      prev_sclk = bus.spi_sclk;
    end
  end

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired with %0d bytes pending", q_miso.size());
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic       any_low;
    logic [5:0] idx;
    logic [7:0] b;
    bus.spi_cs   = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b1;
    rst_n        = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_miso", 32'(bus.spi_miso), 32'(1));
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'(0));
    chk("rst_mem_lba", bus.mem_lba, 32'(0));
    chk("rst_mem_offset", 32'(bus.mem_offset), 32'(0));
    chk("rst_idle", 32'(bus.idle_state), 32'(1));
    chk("rst_cmd_strobe", 32'(bus.cmd_strobe), 32'(0));
    chk("rst_cmd_index", 32'(bus.cmd_index), 32'(0));
    chk("rst_cmd_arg", bus.cmd_arg, 32'(0));

    // Deselected clocking must be ignored
    any_low = 1'b0;
    for (int i = 0; i < 80; i++) begin
      repeat (HALF) @(negedge clk);
      bus.spi_sclk = 1'b1;
      any_low |= ~bus.spi_miso;
      repeat (HALF) @(negedge clk);
      bus.spi_sclk = 1'b0;
      any_low |= ~bus.spi_miso;
    end
    chk("cs_high_miso_low_seen", 32'(any_low), 32'(0));
    chk("cs_high_strobes", 32'(strobe_count), 32'(0));
    chk("cs_high_idle", 32'(bus.idle_state), 32'(1));

    bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);

    cmd(6'd17, 32'd5, 8'h01, -1);
    cmd(6'd0, 32'd0, 8'h95, -1);
    chk("idle_after_cmd0", 32'(bus.idle_state), 32'(1));
    cmd(6'd8, 32'h0000_01AA, 8'h87, -1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("idle_before_last_acmd41", 32'(bus.idle_state), 32'(1));
      cmd(6'd55, 32'd0, 8'h65, -1);
      cmd(6'd41, 32'h4000_0000, 8'h77, -1);
    end
    chk("idle_after_init", 32'(bus.idle_state), 32'(0));
    cmd(6'd58, 32'd0, 8'hFD, -1);

    cmd(6'd17, 32'd5, 8'h01, -1);
    chk("cmd17_rd_pulses", 32'(rd_count - rd_base), 32'(512));
    chk("cmd17_mem_lba", bus.mem_lba, 32'd5);

    // Deselect in the middle of the data phase
    cmd(6'd17, $urandom, 8'h01, 64);
    bus.spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    chk("cs_abort_miso", 32'(bus.spi_miso), 32'(1));
    bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    cmd(6'd58, 32'd0, 8'hFD, -1);

    // Asynchronous reset in the middle of the data phase
    cmd(6'd17, $urandom, 8'h01, 10);
    rst_n = 1'b0;
    #1;
    chk("rst_abort_miso", 32'(bus.spi_miso), 32'(1));
    chk("rst_abort_mem_rd", 32'(bus.mem_rd), 32'(0));
    chk("rst_abort_idle", 32'(bus.idle_state), 32'(1));
    chk("rst_abort_cmd_index", 32'(bus.cmd_index), 32'(0));
    chk("rst_abort_mem_lba", bus.mem_lba, 32'(0));
    m_idle = 1'b1; m_app = 1'b0; m_retry = 0;
    bus.spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus.spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    cmd(6'd0, 32'd0, 8'h95, -1);

    // Randomized command stream, including stray non-frame bytes
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        b = 8'($urandom);
        if (b[7:6] == 2'b01) b[6] = 1'b0;
        xfer(b, 8'hFF);
      end
      case ($urandom_range(0, 6))
        0: idx = 6'd0;
        1: idx = 6'd8;
        2, 3: idx = 6'd55;
        4: idx = 6'd41;
        5: idx = 6'd58;
        default: idx = 6'($urandom);
      endcase
      if (idx == 6'd17 && !m_idle) idx = 6'd58;
      cmd(idx, $urandom, 8'($urandom), -1);
      chk("rand_idle", 32'(bus.idle_state), 32'(m_idle));
    end

    repeat (20) @(negedge clk);
    chk("miso_queue_drained", 32'(q_miso.size()), 32'(0));
    chk("cmd_queue_drained", 32'(q_cmd.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
